// File: rtl/gpio_cond_pkg.sv
// Shared types and constants for the GPIO input conditioner: debounce FSM states,
// default debounce length and the counter width helper.
package gpio_cond_pkg;

    // 10 ms at a 50 MHz system clock.
    localparam int DEFAULT_STABLE_CYCLES = 500000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } db_state_e;

    // Counter only ever holds 0..n-1, so $clog2(n) bits suffice; clamp to 1 bit minimum.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO input bit: 2-flop synchroniser, IDLE/PEND debounce FSM with a stability
// counter, and registered one-cycle rise/fall pulses aligned with the debounced output.
module gpio_debounce_bit
    import gpio_cond_pkg::*;
#(
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic RESET_BIT     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int               CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             s_q, s_d;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_comb begin
        sync1_d = raw_in;
        s_d     = sync1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_q != db_q) begin
                    state_d = ST_PEND;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_PEND: begin
                if (s_q == db_q) begin
                    // Glitch: input returned before it was stable long enough.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    db_d    = ~db_q;
                    rise_d  = ~db_q;
                    fall_d  = db_q;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= RESET_BIT;
            s_q     <= RESET_BIT;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            db_q    <= RESET_BIT;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            s_q     <= s_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign db_out     = db_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: rtl/gpio_in_conditioner.sv
// Conditions the SOPC GPIO input pins: per-bit sync + debounce + edge pulses.
// Optional sticky edge flags and IRQ when GPIO_EVT_IRQ_EN is defined.
module gpio_in_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int               WIDTH         = 8,
    parameter int               STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
`ifdef GPIO_EVT_IRQ_EN
    ,
    output logic [WIDTH-1:0] evt_flags,
    input  logic [WIDTH-1:0] evt_clr,
    output logic             irq
`endif
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            gpio_debounce_bit #(
                .STABLE_CYCLES (STABLE_CYCLES),
                .RESET_BIT     (RESET_VAL[gi])
            ) u_bit (
                .clk        (clk),
                .reset      (reset),
                .raw_in     (raw_in[gi]),
                .db_out     (db_out[gi]),
                .rise_pulse (rise_pulse[gi]),
                .fall_pulse (fall_pulse[gi])
            );
        end
    endgenerate

`ifdef GPIO_EVT_IRQ_EN
    logic [WIDTH-1:0] evt_flags_q, evt_flags_d;
    logic             irq_q, irq_d;

    // A new edge in the same cycle as a clear keeps the flag set.
    always_comb begin
        evt_flags_d = (evt_flags_q & ~evt_clr) | rise_pulse | fall_pulse;
        irq_d       = |evt_flags_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_flags_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            evt_flags_q <= evt_flags_d;
            irq_q       <= irq_d;
        end
    end

    assign evt_flags = evt_flags_q;
    assign irq       = irq_q;
`endif

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner with STABLE_CYCLES=4, RESET_VAL=0.
// Event/IRQ checks run only when GPIO_EVT_IRQ_EN is defined.
module tb_gpio_in_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] raw_in;
    logic [7:0] db_out;
    logic [7:0] rise_pulse;
    logic [7:0] fall_pulse;
`ifdef GPIO_EVT_IRQ_EN
    logic [7:0] evt_flags;
    logic [7:0] evt_clr;
    logic       irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    gpio_in_conditioner #(
        .WIDTH         (8),
        .STABLE_CYCLES (4),
        .RESET_VAL     (8'h00)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (raw_in),
        .db_out     (db_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
`ifdef GPIO_EVT_IRQ_EN
        ,
        .evt_flags  (evt_flags),
        .evt_clr    (evt_clr),
        .irq        (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles; db_out holds db_pre until cycle flip_at, where it becomes db_post
    // with the given pulses; pulses are zero in every other cycle.
    task automatic run_edge(input string tag, input int n, input int flip_at,
                            input logic [7:0] db_pre, input logic [7:0] db_post,
                            input logic [7:0] rise_exp, input logic [7:0] fall_exp);
        for (int k = 1; k <= n; k++) begin
            step();
            if (k < flip_at) begin
                check($sformatf("%s c%0d db", tag, k), db_out, db_pre);
                check($sformatf("%s c%0d rise", tag, k), rise_pulse, 8'h00);
                check($sformatf("%s c%0d fall", tag, k), fall_pulse, 8'h00);
            end else if (k == flip_at) begin
                check($sformatf("%s c%0d db", tag, k), db_out, db_post);
                check($sformatf("%s c%0d rise", tag, k), rise_pulse, rise_exp);
                check($sformatf("%s c%0d fall", tag, k), fall_pulse, fall_exp);
            end else begin
                check($sformatf("%s c%0d db", tag, k), db_out, db_post);
                check($sformatf("%s c%0d rise", tag, k), rise_pulse, 8'h00);
                check($sformatf("%s c%0d fall", tag, k), fall_pulse, 8'h00);
            end
        end
        $display("[TB] %s done: db_out=%02h", tag, db_out);
    endtask

    initial begin
        reset  = 1'b1;
        raw_in = 8'h00;
`ifdef GPIO_EVT_IRQ_EN
        evt_clr = 8'h00;
`endif
        // Reset state
        run_edge("reset", 3, 99, 8'h00, 8'h00, 8'h00, 8'h00);
`ifdef GPIO_EVT_IRQ_EN
        check("reset evt", evt_flags, 8'h00);
        check("reset irq", {7'b0, irq}, 8'h00);
`endif
        reset = 1'b0;
        step();

        // 1: clean rise on bit 0, visible 6 cycles later
        raw_in = 8'h01;
        run_edge("t1 rise0", 7, 6, 8'h00, 8'h01, 8'h01, 8'h00);

        // 2: bounce on bit 3, then a clean hold
        raw_in = 8'h09; run_edge("t2 b1", 1, 99, 8'h01, 8'h01, 8'h00, 8'h00);
        raw_in = 8'h01; run_edge("t2 b2", 1, 99, 8'h01, 8'h01, 8'h00, 8'h00);
        raw_in = 8'h09; run_edge("t2 b3", 1, 99, 8'h01, 8'h01, 8'h00, 8'h00);
        raw_in = 8'h01; run_edge("t2 b4", 1, 99, 8'h01, 8'h01, 8'h00, 8'h00);
        raw_in = 8'h09; run_edge("t2 hold", 8, 6, 8'h01, 8'h09, 8'h08, 8'h00);

        // 3: all bits high, then all low together
        raw_in = 8'hFF; run_edge("t3 up", 7, 6, 8'h09, 8'hFF, 8'hF6, 8'h00);
        raw_in = 8'h00; run_edge("t3 down", 7, 6, 8'hFF, 8'h00, 8'h00, 8'hFF);

        // 4: reset three cycles into a debounce aborts it
        raw_in = 8'h01; run_edge("t4 pre", 3, 99, 8'h00, 8'h00, 8'h00, 8'h00);
        reset  = 1'b1;  run_edge("t4 rst", 2, 99, 8'h00, 8'h00, 8'h00, 8'h00);
        reset  = 1'b0;  run_edge("t4 post", 7, 6, 8'h00, 8'h01, 8'h01, 8'h00);

`ifdef GPIO_EVT_IRQ_EN
        // 5: sticky flags and irq
        raw_in = 8'h05; run_edge("t5 rise2", 6, 6, 8'h01, 8'h05, 8'h04, 8'h00);
        check("t5 evt before", evt_flags, 8'h00);
        step();
        check("t5 evt set", evt_flags, 8'h04);
        check("t5 irq lag", {7'b0, irq}, 8'h00);
        step();
        check("t5 irq set", {7'b0, irq}, 8'h01);
        raw_in = 8'h01; run_edge("t5 fall2", 6, 6, 8'h05, 8'h01, 8'h00, 8'h04);
        evt_clr = 8'h04;
        step();
        evt_clr = 8'h00;
        check("t5 set wins", evt_flags, 8'h04);
        check("t5 irq held", {7'b0, irq}, 8'h01);
        evt_clr = 8'h04;
        step();
        evt_clr = 8'h00;
        check("t5 cleared", evt_flags, 8'h00);
        check("t5 irq still", {7'b0, irq}, 8'h01);
        step();
        check("t5 irq clr", {7'b0, irq}, 8'h00);
`endif

        // 6: 3-cycle pulse on bit 7 is filtered
        raw_in = 8'h81; run_edge("t6 pulse", 3, 99, 8'h01, 8'h01, 8'h00, 8'h00);
        raw_in = 8'h01; run_edge("t6 after", 8, 99, 8'h01, 8'h01, 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
